// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit -- instruction fetch (IF) stage of the tiny5 pipeline
//
// Owns the fetch PC and issues in-order word fetches to instruction memory.
// Returned words are buffered in a small queue and handed to ID as
// {pc, instr} over a valid/ready handshake. A redirect flushes the queue,
// marks every in-flight response as stale and restarts fetch at the target.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   QUEUE_DEPTH  queue entries (power of 2, >= 2); also the outstanding-request limit
//
// Ports
//   clk_i             clock
//   reset_i           synchronous active-high reset
//   redirect_i        flush and restart at redirect_pc_i
//   redirect_pc_i     new PC, bits [1:0] ignored
//   imem_req_valid_o  fetch request valid
//   imem_req_ready_i  imem accepts the request
//   imem_req_addr_o   word-aligned fetch address
//   imem_rsp_valid_i  in-order response valid (always accepted)
//   imem_rsp_data_i   fetched instruction word
//   out_valid_o       if_id_o holds a valid entry
//   out_ready_i       ID consumes the entry
//   if_id_o           {pc[63:32], instr[31:0]} (pipeline_if_id_reg_t layout)
//
// Optional feature: define FETCH_STATS_EN to add
//   stat_fetched_o    entries popped to ID (wraps at 2^32)
//   stat_dropped_o    discarded responses plus entries flushed by redirect
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] if_id_o
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched_o,
    output logic [31:0] stat_dropped_o
`endif
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(QUEUE_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [63:0]     r_q_mem [QUEUE_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_q_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   w_drop_cnt_nxt;
    logic [CW-1:0]   w_outstanding_nxt;
    logic [CW:0]     w_credit_sum;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_out_valid;
    logic            w_pop;
    logic [31:0]     w_redirect_pc;

    // Request credit: in-flight plus buffered never exceeds the queue size,
    // so every response is guaranteed a slot. The sum cannot grow without a
    // handshake, so a raised request stays raised until accepted or redirected.
    assign w_credit_sum  = {1'b0, r_outstanding} + {1'b0, r_q_count};
    assign w_req_valid   = !reset_i && !redirect_i && (w_credit_sum < LP_DEPTH);
    assign w_req_fire    = w_req_valid && imem_req_ready_i;
    // A response is stale while draining, and any response arriving with a redirect is stale too.
    assign w_rsp_drop    = imem_rsp_valid_i && ((r_state == ST_DRAIN) || redirect_i);
    assign w_push        = imem_rsp_valid_i && (r_state == ST_RUN) && !redirect_i;
    assign w_out_valid   = !reset_i && !redirect_i && (r_q_count != {CW{1'b0}});
    assign w_pop         = w_out_valid && out_ready_i;
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = reset_i ? 32'h0000_0000 : r_fetch_pc;
    assign out_valid_o      = w_out_valid;
    assign if_id_o          = (reset_i || (r_q_count == {CW{1'b0}})) ? 64'h0 : r_q_mem[r_rd_ptr];

    // Outstanding counter and drop counter next values, plus RUN/DRAIN next state.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_drop_cnt_nxt    = r_drop_cnt;
        w_state_nxt       = r_state;
        case ({w_req_fire, imem_rsp_valid_i})
            2'b10:   w_outstanding_nxt = r_outstanding + CW'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - CW'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase
        // On redirect every request still in flight after this cycle belongs to
        // the old stream. This equals the not-yet-doomed requests minus a kept
        // response arriving now, plus the already-doomed ones (less one if a
        // stale response arrives now), i.e. outstanding minus any response at R.
        if (redirect_i) begin
            w_drop_cnt_nxt = r_outstanding - CW'(imem_rsp_valid_i);
        end else if (w_rsp_drop) begin
            w_drop_cnt_nxt = r_drop_cnt - CW'(1);
        end else begin
            w_drop_cnt_nxt = r_drop_cnt;
        end
        case (r_state)
            ST_RUN: begin
                if (w_drop_cnt_nxt != {CW{1'b0}}) w_state_nxt = ST_DRAIN;
                else                               w_state_nxt = ST_RUN;
            end
            ST_DRAIN: begin
                if (w_drop_cnt_nxt == {CW{1'b0}}) w_state_nxt = ST_RUN;
                else                               w_state_nxt = ST_DRAIN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM state, counters and PCs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= {CW{1'b0}};
            r_drop_cnt    <= {CW{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop_cnt    <= w_drop_cnt_nxt;
            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)     r_rsp_pc   <= r_rsp_pc + 32'd4;
            end
        end
    end

    // Instruction queue: circular buffer, cleared by redirect.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rd_ptr  <= {AW{1'b0}};
            r_wr_ptr  <= {AW{1'b0}};
            r_q_count <= {CW{1'b0}};
            for (int i = 0; i < QUEUE_DEPTH; i++) r_q_mem[i] <= 64'h0;
        end else if (redirect_i) begin
            r_rd_ptr  <= {AW{1'b0}};
            r_wr_ptr  <= {AW{1'b0}};
            r_q_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_q_mem[r_wr_ptr] <= {r_rsp_pc, imem_rsp_data_i};
                r_wr_ptr          <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_q_count <= r_q_count + CW'(1);
                2'b01:   r_q_count <= r_q_count - CW'(1);
                default: r_q_count <= r_q_count;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_stat_fetched;
    logic [31:0] r_stat_dropped;

    // Fetch statistics: pops to ID, and stale responses plus flushed entries.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stat_fetched <= 32'h0;
            r_stat_dropped <= 32'h0;
        end else begin
            r_stat_fetched <= r_stat_fetched + 32'(w_pop);
            r_stat_dropped <= r_stat_dropped + 32'(w_rsp_drop)
                              + (redirect_i ? 32'(r_q_count) : 32'h0);
        end
    end

    assign stat_fetched_o = reset_i ? 32'h0 : r_stat_fetched;
    assign stat_dropped_o = reset_i ? 32'h0 : r_stat_dropped;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit (QUEUE_DEPTH=2, RESET_PC=0).
// The instruction memory model answers in order one cycle after a handshake
// while rsp_en is high, returning addr ^ 32'hDEAD_0000; with rsp_en low the
// accepted requests are held back.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] if_id_o;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_o;
    logic [31:0] stat_dropped_o;
`endif

    logic        rsp_en;
    logic [31:0] pend_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .if_id_o          (if_id_o)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched_o   (stat_fetched_o),
        .stat_dropped_o   (stat_dropped_o)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model: in-order, 1-cycle latency while enabled.
    always @(posedge clk) begin
        if (reset_i) begin
            pend_q.delete();
            imem_rsp_valid_i <= 1'b0;
            imem_rsp_data_i  <= 32'h0;
        end else begin
            if (imem_req_valid_o && imem_req_ready_i) pend_q.push_back(imem_req_addr_o);
            if (rsp_en && pend_q.size() != 0) begin
                imem_rsp_valid_i <= 1'b1;
                imem_rsp_data_i  <= pend_q.pop_front() ^ 32'hDEAD_0000;
            end else begin
                imem_rsp_valid_i <= 1'b0;
                imem_rsp_data_i  <= 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_req_ready_i = 1'b1; out_ready_i = 1'b1; rsp_en = 1'b1;
        imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;

        // Reset cycle: all outputs 0
        cyc(); #1;
        chk("rst_req_valid", 64'(imem_req_valid_o), 64'h0);
        chk("rst_req_addr",  64'(imem_req_addr_o),  64'h0);
        chk("rst_out_valid", 64'(out_valid_o),      64'h0);
        chk("rst_if_id",     if_id_o,               64'h0);

        // Streaming with 0-wait imem, ID always ready
        cyc(); reset_i = 1'b0; #1;                      // C0
        chk("c0_req_valid", 64'(imem_req_valid_o), 64'h1);
        chk("c0_req_addr",  64'(imem_req_addr_o),  64'h0);
        cyc(); #1;                                       // C1
        chk("c1_req_addr",  64'(imem_req_addr_o),  64'h4);
        chk("c1_out_valid", 64'(out_valid_o),      64'h0);
        cyc(); #1;                                       // C2
        chk("c2_out_valid", 64'(out_valid_o),      64'h1);
        chk("c2_if_id",     if_id_o,               64'h0000_0000_DEAD_0000);
        chk("c2_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); #1;                                       // C3
        chk("c3_if_id",     if_id_o,               64'h0000_0004_DEAD_0004);
        chk("c3_req_valid", 64'(imem_req_valid_o), 64'h1);
        chk("c3_req_addr",  64'(imem_req_addr_o),  64'h8);

        // Reset mid-stream
        cyc(); reset_i = 1'b1; #1;                      // C4
        chk("c4_req_valid", 64'(imem_req_valid_o), 64'h0);
        chk("c4_out_valid", 64'(out_valid_o),      64'h0);
        chk("c4_if_id",     if_id_o,               64'h0);
        cyc(); reset_i = 1'b0; out_ready_i = 1'b0; #1; // C5
        chk("c5_req_addr",  64'(imem_req_addr_o),  64'h0);
        chk("c5_req_valid", 64'(imem_req_valid_o), 64'h1);
        chk("c5_out_valid", 64'(out_valid_o),      64'h0);
`ifdef FETCH_STATS_EN
        chk("c5_stat_fetched", 64'(stat_fetched_o), 64'h0);
        chk("c5_stat_dropped", 64'(stat_dropped_o), 64'h0);
`endif

        // ID stalled: only two requests, then the credit closes
        cyc(); #1;                                       // C6
        chk("c6_req_addr",  64'(imem_req_addr_o),  64'h4);
        cyc(); #1;                                       // C7
        chk("c7_out_valid", 64'(out_valid_o),      64'h1);
        chk("c7_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); #1;                                       // C8
        chk("c8_req_valid", 64'(imem_req_valid_o), 64'h0);
        chk("c8_if_id",     if_id_o,               64'h0000_0000_DEAD_0000);
        cyc(); out_ready_i = 1'b1; #1;                  // C9
        chk("c9_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); #1;                                       // C10
        chk("c10_req_valid", 64'(imem_req_valid_o), 64'h1);
        chk("c10_req_addr",  64'(imem_req_addr_o),  64'h8);
        chk("c10_if_id",     if_id_o,               64'h0000_0004_DEAD_0004);

        // imem back-pressure: request holds for three cycles
        cyc(); reset_i = 1'b1; #1;                      // C11
        cyc(); reset_i = 1'b0; #1;                      // C12
        chk("c12_req_addr", 64'(imem_req_addr_o),  64'h0);
        cyc(); imem_req_ready_i = 1'b0; #1;             // C13
        chk("c13_req_valid", 64'(imem_req_valid_o), 64'h1);
        chk("c13_req_addr",  64'(imem_req_addr_o),  64'h4);
        cyc(); #1;                                       // C14
        chk("c14_req_addr",  64'(imem_req_addr_o),  64'h4);
        chk("c14_if_id",     if_id_o,               64'h0000_0000_DEAD_0000);
        cyc(); #1;                                       // C15
        chk("c15_req_valid", 64'(imem_req_valid_o), 64'h1);
        chk("c15_req_addr",  64'(imem_req_addr_o),  64'h4);
        cyc(); imem_req_ready_i = 1'b1; #1;             // C16
        chk("c16_req_addr",  64'(imem_req_addr_o),  64'h4);
        cyc(); imem_req_ready_i = 1'b0; #1;             // C17
        chk("c17_req_addr",  64'(imem_req_addr_o),  64'h8);
        cyc(); #1;                                       // C18
        chk("c18_if_id",     if_id_o,               64'h0000_0004_DEAD_0004);

        // Redirect with two outstanding requests
        cyc(); reset_i = 1'b1; #1;                      // C19
        cyc(); reset_i = 1'b0; imem_req_ready_i = 1'b1; rsp_en = 1'b0; #1; // C20
        chk("c20_req_addr", 64'(imem_req_addr_o),  64'h0);
        cyc(); #1;                                       // C21
        chk("c21_req_addr", 64'(imem_req_addr_o),  64'h4);
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; rsp_en = 1'b1; #1; // C22
        chk("c22_req_valid", 64'(imem_req_valid_o), 64'h0);
        chk("c22_out_valid", 64'(out_valid_o),      64'h0);
        cyc(); redirect_i = 1'b0; #1;                   // C23
        chk("c23_req_valid", 64'(imem_req_valid_o), 64'h0);
        chk("c23_out_valid", 64'(out_valid_o),      64'h0);
        cyc(); #1;                                       // C24
        chk("c24_req_valid", 64'(imem_req_valid_o), 64'h1);
        chk("c24_req_addr",  64'(imem_req_addr_o),  64'h100);
        chk("c24_out_valid", 64'(out_valid_o),      64'h0);
        cyc(); #1;                                       // C25
        chk("c25_req_addr",  64'(imem_req_addr_o),  64'h104);
        chk("c25_out_valid", 64'(out_valid_o),      64'h0);
`ifdef FETCH_STATS_EN
        chk("c25_stat_dropped", 64'(stat_dropped_o), 64'h2);
`endif
        cyc(); #1;                                       // C26
        chk("c26_out_valid", 64'(out_valid_o),      64'h1);
        chk("c26_if_id",     if_id_o,               64'h0000_0100_DEAD_0100);

        // Redirect with a response arriving, then with a full stalled queue
        cyc(); reset_i = 1'b1; out_ready_i = 1'b0; #1;  // C27
        cyc(); reset_i = 1'b0; #1;                       // C28
        chk("c28_req_addr", 64'(imem_req_addr_o),  64'h0);
        cyc(); #1;                                       // C29
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; #1; // C30
        chk("c30_rsp_live",  64'(imem_rsp_valid_i), 64'h1);
        chk("c30_out_valid", 64'(out_valid_o),      64'h0);
        chk("c30_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); redirect_i = 1'b0; #1;                   // C31
        chk("c31_out_valid", 64'(out_valid_o),      64'h0);
        chk("c31_req_addr",  64'(imem_req_addr_o),  64'h200);
        chk("c31_req_valid", 64'(imem_req_valid_o), 64'h1);
`ifdef FETCH_STATS_EN
        chk("c31_stat_dropped", 64'(stat_dropped_o), 64'h2);
`endif
        cyc(); #1;                                       // C32
        chk("c32_req_addr",  64'(imem_req_addr_o),  64'h204);
        cyc(); #1;                                       // C33
        chk("c33_if_id",     if_id_o,               64'h0000_0200_DEAD_0200);
        chk("c33_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300; #1; // C34
        chk("c34_out_valid", 64'(out_valid_o),      64'h0);
        chk("c34_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); redirect_i = 1'b0; rsp_en = 1'b0; #1;    // C35
        chk("c35_out_valid", 64'(out_valid_o),      64'h0);
        chk("c35_req_addr",  64'(imem_req_addr_o),  64'h300);
`ifdef FETCH_STATS_EN
        chk("c35_stat_dropped", 64'(stat_dropped_o), 64'h4);
`endif

        // Back-to-back redirects with two stale requests in flight
        cyc(); #1;                                       // C36
        chk("c36_req_addr",  64'(imem_req_addr_o),  64'h304);
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0400; #1; // C37
        chk("c37_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); redirect_pc_i = 32'h0000_0500; rsp_en = 1'b1; #1;     // C38
        chk("c38_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); redirect_i = 1'b0; #1;                   // C39
        chk("c39_req_valid", 64'(imem_req_valid_o), 64'h0);
        cyc(); #1;                                       // C40
        chk("c40_req_addr",  64'(imem_req_addr_o),  64'h500);
        chk("c40_req_valid", 64'(imem_req_valid_o), 64'h1);
        cyc(); #1;                                       // C41
        chk("c41_req_addr",  64'(imem_req_addr_o),  64'h504);
        cyc(); out_ready_i = 1'b1; #1;                  // C42
        chk("c42_out_valid", 64'(out_valid_o),      64'h1);
        chk("c42_if_id",     if_id_o,               64'h0000_0500_DEAD_0500);
`ifdef FETCH_STATS_EN
        chk("c42_stat_dropped", 64'(stat_dropped_o), 64'h6);
        chk("c42_stat_fetched", 64'(stat_fetched_o), 64'h0);
`endif
        cyc(); #1;                                       // C43
        chk("c43_if_id",     if_id_o,               64'h0000_0504_DEAD_0504);
`ifdef FETCH_STATS_EN
        chk("c43_stat_fetched", 64'(stat_fetched_o), 64'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
